// File: rtl/mc_pkg.sv
// Shared constants for the multicycle controller: state codes, opcode/funct
// values, datapath select encodings and the per-instruction ALU setup.
package mc_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC   = 4'd2;
    localparam logic [3:0] S_MEM_RD = 4'd3;
    localparam logic [3:0] S_MEM_WR = 4'd4;
    localparam logic [3:0] S_WB_ALU = 4'd5;
    localparam logic [3:0] S_WB_MEM = 4'd6;
    localparam logic [3:0] S_BRANCH = 4'd7;
    localparam logic [3:0] S_JUMP   = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;
    localparam logic [1:0] M2R_SLT = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    typedef enum logic [3:0] {
        OP_ADDU, OP_SUBU, OP_SLT, OP_JR, OP_ADDI, OP_ORI,
        OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL
    } op_class_t;

    typedef struct packed {
        logic [1:0] aluctr;
        logic       alusrc;
        logic [1:0] extop;
    } alu_ctrl_t;

    function automatic alu_ctrl_t alu_ctrl_for(input op_class_t op);
        alu_ctrl_t c;
        c = '{aluctr: ALU_ADD, alusrc: 1'b0, extop: EXT_ZERO};
        case (op)
            OP_SUBU:             c = '{aluctr: ALU_SUB, alusrc: 1'b0, extop: EXT_ZERO};
            OP_SLT:              c = '{aluctr: ALU_SLT, alusrc: 1'b0, extop: EXT_ZERO};
            OP_ADDI, OP_LW, OP_SW: c = '{aluctr: ALU_ADD, alusrc: 1'b1, extop: EXT_SIGN};
            OP_ORI:              c = '{aluctr: ALU_OR,  alusrc: 1'b1, extop: EXT_ZERO};
            OP_LUI:              c = '{aluctr: ALU_OR,  alusrc: 1'b1, extop: EXT_UPPER};
            // branch offset is sign-extended; the ALU compares registers
            OP_BEQ:              c = '{aluctr: ALU_SUB, alusrc: 1'b0, extop: EXT_SIGN};
            default:             c = '{aluctr: ALU_ADD, alusrc: 1'b0, extop: EXT_ZERO};
        endcase
        return c;
    endfunction

    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: classifies the instruction register
// contents into an op class and flags unsupported encodings.
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] ins,
    output op_class_t   op_class,
    output logic        illegal
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_bits;

    assign opcode = ins[31:26];
    assign funct  = ins[5:0];
    // operand fields are not part of the decode
    assign unused_bits = ^ins[25:6];

    always_comb begin
        op_class = OP_ADDU;
        illegal  = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                case (funct)
                    FN_ADDU: op_class = OP_ADDU;
                    FN_SUBU: op_class = OP_SUBU;
                    FN_SLT:  op_class = OP_SLT;
                    FN_JR:   op_class = OP_JR;
                    default: illegal  = 1'b1;
                endcase
            end
            OPC_ADDI: op_class = OP_ADDI;
            OPC_ORI:  op_class = OP_ORI;
            OPC_LUI:  op_class = OP_LUI;
            OPC_LW:   op_class = OP_LW;
            OPC_SW:   op_class = OP_SW;
            OPC_BEQ:  op_class = OP_BEQ;
            OPC_J:    op_class = OP_J;
            OPC_JAL:  op_class = OP_JAL;
            default:  illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle CPU control FSM with memory-wait timeout and sticky error.
// Optional MC_CTRL_PERF_EN adds a 32-bit instruction counter output.
module mc_controller
    import mc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ins,
    input  logic        zero,
    input  logic        overflow,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alusrc,
    output logic [1:0]  pc_src,
    output logic [1:0]  regdst,
    output logic [1:0]  memtoreg,
    output logic [1:0]  aluctr,
    output logic [1:0]  extop,
    output logic [3:0]  state,
    output logic        err
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] instr_cnt
`endif
);

    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [3:0]        state_reg, state_next;
    op_class_t         op_reg, op_next;
    logic [WCNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              err_reg, err_next;

    op_class_t         dec_op;
    logic              dec_illegal;
    logic              in_mem;
    logic              timed_out;
    alu_ctrl_t         alu_cfg;

    mc_decode u_decode (
        .ins      (ins),
        .op_class (dec_op),
        .illegal  (dec_illegal)
    );

    assign in_mem    = is_mem_state(state_reg);
    assign timed_out = in_mem && !mem_ready &&
                       (wait_cnt_reg == WCNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        err_next   = err_reg;
        case (state_reg)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                op_next = dec_op;
                if (dec_illegal) begin
                    state_next = S_HALT;
                    err_next   = 1'b1;
                end else if (dec_op inside {OP_J, OP_JAL, OP_JR}) begin
                    state_next = S_JUMP;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_reg)
                    OP_LW:   state_next = S_MEM_RD;
                    OP_SW:   state_next = S_MEM_WR;
                    OP_BEQ:  state_next = S_BRANCH;
                    default: state_next = S_WB_ALU;
                endcase
            end
            S_MEM_RD: if (mem_ready) state_next = S_WB_MEM;
            S_MEM_WR: if (mem_ready) state_next = S_FETCH;
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default: begin
                state_next = S_HALT;
                err_next   = 1'b1;
            end
        endcase
        if (timed_out) begin
            state_next = S_HALT;
            err_next   = 1'b1;
        end
    end

    // counter restarts whenever a memory state is (re)entered
    always_comb begin
        wait_cnt_next = '0;
        if (in_mem && (state_next == state_reg))
            wait_cnt_next = wait_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_FETCH;
            op_reg       <= OP_ADDU;
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            wait_cnt_reg <= wait_cnt_next;
            err_reg      <= err_next;
        end
    end

    // ALU setup chosen in EXEC is held through the dependent state so the
    // flags and address stay valid while they are consumed.
    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alusrc    = 1'b0;
        pc_src    = PC_PLUS4;
        regdst    = RD_RT;
        memtoreg  = M2R_ALU;
        aluctr    = ALU_ADD;
        extop     = EXT_ZERO;
        alu_cfg   = alu_ctrl_for(op_reg);
        if (rst) begin
            if (state_reg inside {S_EXEC, S_MEM_RD, S_MEM_WR, S_WB_ALU, S_BRANCH}) begin
                aluctr = alu_cfg.aluctr;
                alusrc = alu_cfg.alusrc;
                extop  = alu_cfg.extop;
            end
            case (state_reg)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_MEM_RD: mem_read  = 1'b1;
                S_MEM_WR: mem_write = 1'b1;
                S_WB_ALU: begin
                    reg_write = !((op_reg == OP_ADDI) && overflow);
                    regdst    = (op_reg inside {OP_ADDU, OP_SUBU, OP_SLT}) ? RD_RD : RD_RT;
                    memtoreg  = (op_reg == OP_SLT) ? M2R_SLT : M2R_ALU;
                end
                S_WB_MEM: begin
                    reg_write = 1'b1;
                    memtoreg  = M2R_MEM;
                    regdst    = RD_RT;
                end
                S_BRANCH: begin
                    pc_write = zero;
                    pc_src   = PC_BRANCH;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = (op_reg == OP_JR) ? PC_REG : PC_JUMP;
                    if (op_reg == OP_JAL) begin
                        reg_write = 1'b1;
                        regdst    = RD_RA;
                        memtoreg  = M2R_PC4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state = state_reg;
    assign err   = err_reg;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] instr_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            instr_cnt_reg <= 32'd0;
        else if ((state_next == S_FETCH) && (state_reg != S_FETCH))
            instr_cnt_reg <= instr_cnt_reg + 32'd1;
    end

    assign instr_cnt = instr_cnt_reg;
`endif

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 15: maximum wait cycles for mem_ready before the block declares an error.
REQ-002 SHALL have ports: clk  in  1  clock (all state updates on rising edge).
REQ-003 rst  in  1  reset (one clock; reset is asynchronous and active-low).
REQ-004 ins  in  32  current instruction register contents.
REQ-005 zero, overflow  in  1 each  ALU flags.
REQ-006 mem_ready  in  1  memory access complete this cycle.
REQ-007 pc_write, ir_write, reg_write, mem_read, mem_write, alusrc  out  1 each  datapath strobes and selects.
REQ-008 pc_src  out  2  next-PC select: 00 pc+4, 01 branch target, 10 jump target, 11 register rs.
REQ-009 regdst  out  2  destination register: 00 rt, 01 rd, 10 $31.
REQ-010 memtoreg  out  2  write-back source: 00 alu, 01 memory, 10 pc+4, 11 slt.
REQ-011 aluctr  out  2  ALU operation: 00 add, 01 sub, 10 or, 11 slt.
REQ-012 extop  out  2  immediate extension: 00 zero, 01 sign, 10 upper (lui).
REQ-013 state  out  4  current FSM state code; err  out  1  sticky error (illegal op or timeout).

Function
REQ-014 FSM states, with codes: FETCH=0, DECODE=1, EXEC=2, MEM_RD=3, MEM_WR=4, WB_ALU=5, WB_MEM=6, BRANCH=7, JUMP=8, HALT=9.
REQ-015 FETCH: mem_read=1 until mem_ready; on mem_ready pulse ir_write and pc_write with pc_src=00, then go to DECODE.
REQ-016 DECODE: one cycle; opcode/funct decode of ins; illegal encoding goes to HALT with err=1.
REQ-017 Supported instructions: addu, subu, slt, jr (R-type), addi, ori, lui, lw, sw, beq, j, jal.
REQ-018 EXEC sets aluctr/alusrc/extop per op: lw/sw/addi use add, sign extension, alusrc=1; ori uses or, zero extension; lui uses or, upper extension; beq uses sub.
REQ-019 EXEC then goes to MEM_RD for lw, MEM_WR for sw, BRANCH for beq, and WB_ALU for all others.
REQ-020 MEM_RD/MEM_WR assert mem_read/mem_write until mem_ready; MEM_RD then goes to WB_MEM, MEM_WR goes to FETCH.
REQ-021 WB_ALU: reg_write=1 for one cycle; for addi with overflow=1 reg_write SHALL be 0; slt selects memtoreg=11.
REQ-022 WB_MEM: reg_write=1, memtoreg=01, regdst=00.
REQ-023 BRANCH: pc_write=1 with pc_src=01 only if zero=1; always goes to FETCH.
REQ-024 JUMP, reached from DECODE for j/jal/jr: pc_write=1; pc_src=10 for j/jal, 11 for jr; jal also writes reg_write=1, regdst=10, memtoreg=10.
REQ-025 Strobes SHALL be Moore outputs, except the FETCH, MEM_RD and MEM_WR completion strobes, which are qualified by mem_ready in the same cycle.
REQ-026 The wait counter SHALL reset on entering each memory state; reaching TIMEOUT_CYC cycles without mem_ready goes to HALT and sets err=1.
REQ-027 HALT: all strobes 0; remain in HALT until reset.
REQ-028 mem_ready while not in a memory state SHALL be ignored.

Reset
REQ-029 rst=0 SHALL immediately force state=FETCH, err=0, all strobes 0, all selects 00, and wait counter 0.
REQ-030 Reset mid-access SHALL abandon the access; the first post-reset cycle asserts mem_read in FETCH.

Configuration
REQ-031 Macro MC_CTRL_PERF_EN SHALL add output instr_cnt (32 bits): it resets to 0, increments on every entry to FETCH after reset, and wraps from 0xFFFFFFFF to 0.
REQ-032 Without MC_CTRL_PERF_EN, the port and counter SHALL be absent.

Structure
REQ-033 State codes, opcode/funct constants and the 2-bit select encodings SHALL live in shared package mc_pkg.
REQ-034 The combinational instruction decoder SHALL be sub-module mc_decode (ins -> op class, illegal); the FSM stays in mc_controller.

Verification
REQ-035 lw: ins=0x8C220004, mem_ready after 2 wait cycles -> FETCH, DECODE, EXEC, MEM_RD (3 cycles), WB_MEM with reg_write=1, memtoreg=01.
REQ-036 beq: ins=0x10220003 with zero=1 -> BRANCH with pc_write=1, pc_src=01; with zero=0 -> pc_write=0.
REQ-037 jal: ins=0x0C000010 -> JUMP with pc_src=10, reg_write=1, regdst=10, memtoreg=10.
REQ-038 addi: ins=0x20420001 with overflow=1 -> WB_ALU with reg_write=0.
REQ-039 mem_ready held 0 for 15 cycles in FETCH -> HALT, err=1; illegal ins=0xFC000000 -> HALT, err=1.
REQ-040 rst asserted during MEM_WR -> state=0 and mem_write=0 immediately; with MC_CTRL_PERF_EN, instr_cnt=0.
